order_book_matcher: RTL and testbench
=====================================

# order_book_matcher

Parametrised successor to the 8-entry matching engine: keeps a bounded limit order book per side (price + quantity), accepts orders through valid/ready handshakes, and executes at most one trade per cycle between best bid and best ask with partial fills and removal of filled orders. Sits between the order-entry front end and the VGA analytics path, which consumes `best_bid`, `best_ask`, book occupancy and the trade stream.

## Interface
- `PRICE_W`, 8: price width, unsigned.
- `QTY_W`, 8: quantity width, unsigned; qty 0 orders are rejected (accepted, discarded).
- `DEPTH`, 8: slots per side, ≥2.
- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears both books and all registered outputs.
- `buy_valid` / `buy_ready` in/out 1: buy order handshake; transfer when both high.
- `buy_price` in PRICE_W, `buy_qty` in QTY_W: buy order payload.
- `sell_valid` / `sell_ready` in/out 1; `sell_price` in PRICE_W, `sell_qty` in QTY_W: sell side.
- `trade_valid` out 1: one-cycle pulse per executed trade.
- `trade_price` out PRICE_W, `trade_qty` out QTY_W: trade payload, held until next trade.
- `best_bid` / `best_ask` out PRICE_W: highest resting bid / lowest resting ask; 0 / all-ones when side empty.
- `bid_count` / `ask_count` out $clog2(DEPTH+1): resting orders per side.
- `trade_count` out 16: saturating count of trades since reset.

## Operation
- Each side: DEPTH slots, each {valid, price, qty}, kept compacted in arrival order (slot 0 oldest).
- `buy_ready` = bid_count < DEPTH, from registered count only (no same-cycle credit for a removal); likewise `sell_ready`.
- Accepted order appended at first free slot after this cycle's removal compaction.
- Best search (combinational): max price on bid side, min on ask side; ties resolved to lowest slot index (time priority).
- Match condition: both sides non-empty and best_bid ≥ best_ask. No sentinel-price special casing; emptiness comes from valid bits.
- On match: fill = min(bid qty, ask qty); both entries decremented by fill; entry reaching 0 removed and younger entries shift down one slot; both removed if equal.
- trade_price = (best_bid + best_ask) >> 1 computed in PRICE_W+1 bits, truncated toward zero.
- One trade per cycle max; a crossed book drains over successive cycles.
- Orders arriving in cycle N are never matched in cycle N.
- trade_count saturates at 16'hFFFF.

## Timing
- Order handshake in cycle N → visible in book/best/count outputs at N+1.
- Match evaluated on book state in cycle N+1 → `trade_valid`, `trade_price`, `trade_qty` registered at N+2, book updated at N+2.
- Crossed book with k fills required → k consecutive trade_valid pulses.
- Simultaneous buy insert, sell insert and trade in one cycle: all three applied; insert position computed after removal.
- Full side with a removal in the same cycle: ready stays low that cycle; rises next cycle.
- Reset mid-operation: books empty, counts 0, best_bid 0, best_ask all-ones, trade_valid 0, trade_price 0, trade_qty 0, trade_count 0, both ready high after reset deasserts.

## Structure
- Package `ob_pkg`: default widths, `BID_EMPTY` (0) / `ASK_EMPTY` (all-ones) constants, order-entry struct {valid, price, qty}.
- Sub-module `ob_side` (parameter IS_BID selects max/min search), instantiated twice: storage, append, best search returning index/price/qty, decrement-and-compact on fill.
- Top: handshake, match comparison, fill computation, trade registers, trade_count.

## Test plan
- Reset, idle: best_bid 0, best_ask 255, counts 0, both ready 1, no trade_valid.
- Buy 100×10 then sell 90×4: one trade, price 95, qty 4; bid remains 100 qty 6, ask empty.
- Bids 100×5 (t0), 100×5 (t1); sell 95×5: trade with older bid; bid_count 1 after; price 97.
- Sell 100×20 against bids 105×5, 103×5, 101×5: three consecutive trade_valid pulses, prices 102, 101, 100, ask qty 5 left.
- Fill 8 non-crossing bids (price 50): buy_ready 0; cross with sell 40×1 qty removing one: ready 1 the cycle after removal, not before.
- Assert reset during drain sequence: all outputs to reset values asynchronously, next order handled normally.

Source files
------------

// File: rtl/ob_pkg.sv
// ob_pkg: default book widths, empty-side price sentinels and the order entry type
package ob_pkg;
  localparam int DEF_PRICE_W = 8;
  localparam int DEF_QTY_W = 8;
  localparam int DEF_DEPTH = 8;
  localparam logic [DEF_PRICE_W-1:0] BID_EMPTY = '0;
  localparam logic [DEF_PRICE_W-1:0] ASK_EMPTY = '1;
  typedef struct packed {
    logic                   valid;
    logic [DEF_PRICE_W-1:0] price;
    logic [DEF_QTY_W-1:0]   qty;
  } order_t;
endpackage

// File: rtl/ob_side.sv
// ob_side: one side of the book, compacted in arrival order, with best search,
// fill/removal of the best entry and append after removal.
module ob_side import ob_pkg::*; #(
  parameter bit IS_BID = 1'b1,
  parameter int PRICE_W = DEF_PRICE_W,
  parameter int QTY_W = DEF_QTY_W,
  parameter int DEPTH = DEF_DEPTH,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ins_valid,
  input  logic [PRICE_W-1:0] ins_price,
  input  logic [QTY_W-1:0]   ins_qty,
  input  logic               fill_valid,
  input  logic [QTY_W-1:0]   fill_qty,
  output logic               found,
  output logic [PRICE_W-1:0] best_price,
  output logic [QTY_W-1:0]   best_qty,
  output logic [CW-1:0]      count
);
  typedef struct packed {
    logic               valid;
    logic [PRICE_W-1:0] price;
    logic [QTY_W-1:0]   qty;
  } entry_t;
  entry_t slot_q [DEPTH];
  entry_t slot_d [DEPTH];
  logic [CW-1:0] count_q, count_d, best_idx, ins_idx;
  logic [PRICE_W-1:0] scan_price;
  logic [QTY_W-1:0] left_qty;
  logic removed;
  // Strict compare keeps the oldest slot on equal prices.
  always_comb begin
    found = 1'b0;
    best_idx = '0;
    scan_price = '0;
    best_qty = '0;
    for (int i = 0; i < DEPTH; i++)
      if (slot_q[i].valid && (!found || (IS_BID ? slot_q[i].price > scan_price : slot_q[i].price < scan_price))) begin
        found = 1'b1;
        best_idx = CW'(i);
        scan_price = slot_q[i].price;
        best_qty = slot_q[i].qty;
      end
    best_price = found ? scan_price : {PRICE_W{~IS_BID}};
  end
  always_comb begin
    slot_d = slot_q;
    left_qty = best_qty - fill_qty;
    removed = fill_valid && left_qty == '0;
    for (int i = 0; i < DEPTH; i++)
      if (fill_valid && CW'(i) == best_idx) slot_d[i].qty = left_qty;
    for (int i = 0; i < DEPTH - 1; i++)
      if (removed && CW'(i) >= best_idx) slot_d[i] = slot_q[i + 1];
    if (removed) slot_d[DEPTH-1] = '0;
    ins_idx = count_q - CW'(removed);
    for (int i = 0; i < DEPTH; i++)
      if (ins_valid && CW'(i) == ins_idx) slot_d[i] = '{1'b1, ins_price, ins_qty};
    count_d = ins_idx + CW'(ins_valid);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      slot_q <= '{default: '0};
      count_q <= '0;
    end else begin
      slot_q <= slot_d;
      count_q <= count_d;
    end
  assign count = count_q;
endmodule

// File: rtl/order_book_matcher.sv
// order_book_matcher: two bounded limit-order books with valid/ready entry and
// at most one best-bid/best-ask trade per cycle, midpoint priced, partial fills.
module order_book_matcher import ob_pkg::*; #(
  parameter int PRICE_W = DEF_PRICE_W,
  parameter int QTY_W = DEF_QTY_W,
  parameter int DEPTH = DEF_DEPTH,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               buy_valid,
  output logic               buy_ready,
  input  logic [PRICE_W-1:0] buy_price,
  input  logic [QTY_W-1:0]   buy_qty,
  input  logic               sell_valid,
  output logic               sell_ready,
  input  logic [PRICE_W-1:0] sell_price,
  input  logic [QTY_W-1:0]   sell_qty,
  output logic               trade_valid,
  output logic [PRICE_W-1:0] trade_price,
  output logic [QTY_W-1:0]   trade_qty,
  output logic [PRICE_W-1:0] best_bid,
  output logic [PRICE_W-1:0] best_ask,
  output logic [CW-1:0]      bid_count,
  output logic [CW-1:0]      ask_count,
  output logic [15:0]        trade_count
);
  logic bid_found, ask_found, match, bid_ins, ask_ins;
  logic [QTY_W-1:0] bid_qty, ask_qty, fill;
  logic [PRICE_W:0] sum;
  logic trade_valid_q, trade_valid_d;
  logic [PRICE_W-1:0] trade_price_q, trade_price_d;
  logic [QTY_W-1:0] trade_qty_q, trade_qty_d;
  logic [15:0] trade_count_q, trade_count_d;
  assign buy_ready = bid_count < CW'(DEPTH);
  assign sell_ready = ask_count < CW'(DEPTH);
  // Zero-quantity orders complete the handshake but never enter the book.
  assign bid_ins = buy_valid && buy_ready && buy_qty != '0;
  assign ask_ins = sell_valid && sell_ready && sell_qty != '0;
  assign match = bid_found && ask_found && best_bid >= best_ask;
  assign fill = bid_qty < ask_qty ? bid_qty : ask_qty;
  assign sum = {1'b0, best_bid} + {1'b0, best_ask};
  ob_side #(.IS_BID(1'b1), .PRICE_W(PRICE_W), .QTY_W(QTY_W), .DEPTH(DEPTH)) u_bid (
    .clk(clk), .reset(reset), .ins_valid(bid_ins), .ins_price(buy_price), .ins_qty(buy_qty),
    .fill_valid(match), .fill_qty(fill), .found(bid_found), .best_price(best_bid),
    .best_qty(bid_qty), .count(bid_count)
  );
  ob_side #(.IS_BID(1'b0), .PRICE_W(PRICE_W), .QTY_W(QTY_W), .DEPTH(DEPTH)) u_ask (
    .clk(clk), .reset(reset), .ins_valid(ask_ins), .ins_price(sell_price), .ins_qty(sell_qty),
    .fill_valid(match), .fill_qty(fill), .found(ask_found), .best_price(best_ask),
    .best_qty(ask_qty), .count(ask_count)
  );
  always_comb begin
    trade_valid_d = match;
    trade_price_d = match ? PRICE_W'(sum >> 1) : trade_price_q;
    trade_qty_d = match ? fill : trade_qty_q;
    trade_count_d = match && trade_count_q != 16'hFFFF ? trade_count_q + 16'd1 : trade_count_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      trade_valid_q <= 1'b0;
      trade_price_q <= '0;
      trade_qty_q <= '0;
      trade_count_q <= '0;
    end else begin
      trade_valid_q <= trade_valid_d;
      trade_price_q <= trade_price_d;
      trade_qty_q <= trade_qty_d;
      trade_count_q <= trade_count_d;
    end
  assign trade_valid = trade_valid_q;
  assign trade_price = trade_price_q;
  assign trade_qty = trade_qty_q;
  assign trade_count = trade_count_q;
endmodule

// File: tb/tb_order_book_matcher.sv
// tb_order_book_matcher: directed scenarios with hand-computed book and trade expectations.
module tb_order_book_matcher;
  import ob_pkg::*;
  logic clk = 1'b0, reset = 1'b1;
  logic buy_valid = 1'b0, sell_valid = 1'b0;
  logic buy_ready, sell_ready, trade_valid;
  logic [7:0] buy_price = '0, buy_qty = '0, sell_price = '0, sell_qty = '0;
  logic [7:0] trade_price, trade_qty, best_bid, best_ask;
  logic [3:0] bid_count, ask_count;
  logic [15:0] trade_count;
  int tests = 0, failed = 0;
  localparam order_t NONE = '0;

  order_book_matcher dut (
    .clk(clk), .reset(reset),
    .buy_valid(buy_valid), .buy_ready(buy_ready), .buy_price(buy_price), .buy_qty(buy_qty),
    .sell_valid(sell_valid), .sell_ready(sell_ready), .sell_price(sell_price), .sell_qty(sell_qty),
    .trade_valid(trade_valid), .trade_price(trade_price), .trade_qty(trade_qty),
    .best_bid(best_bid), .best_ask(best_ask), .bid_count(bid_count), .ask_count(ask_count),
    .trade_count(trade_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  function automatic order_t ord(input logic [7:0] p, input logic [7:0] q);
    return '{1'b1, p, q};
  endfunction

  task automatic step(input order_t b, input order_t s);
    buy_valid = b.valid; buy_price = b.price; buy_qty = b.qty;
    sell_valid = s.valid; sell_price = s.price; sell_qty = s.qty;
    @(negedge clk);
    buy_valid = 1'b0; sell_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    do_reset();
    tests++; if (best_bid !== BID_EMPTY) begin failed++; $display("FAIL rst_best_bid: got %0d expected 0", best_bid); end
    tests++; if (best_ask !== ASK_EMPTY) begin failed++; $display("FAIL rst_best_ask: got %0d expected 255", best_ask); end
    tests++; if (bid_count !== 4'd0 || ask_count !== 4'd0) begin failed++; $display("FAIL rst_counts: got %0d/%0d expected 0/0", bid_count, ask_count); end
    tests++; if (buy_ready !== 1'b1 || sell_ready !== 1'b1) begin failed++; $display("FAIL rst_ready: got %0b/%0b expected 1/1", buy_ready, sell_ready); end
    step(NONE, NONE);
    tests++; if (trade_valid !== 1'b0 || trade_count !== 16'd0) begin failed++; $display("FAIL idle_trade: got valid %0b count %0d expected 0/0", trade_valid, trade_count); end
  endtask

  task automatic test_zero_qty();
    do_reset();
    step(ord(8'd100, 8'd0), ord(8'd50, 8'd0));
    tests++; if (bid_count !== 4'd0 || ask_count !== 4'd0) begin failed++; $display("FAIL zero_qty_counts: got %0d/%0d expected 0/0", bid_count, ask_count); end
    tests++; if (best_bid !== 8'd0 || best_ask !== 8'd255) begin failed++; $display("FAIL zero_qty_best: got %0d/%0d expected 0/255", best_bid, best_ask); end
  endtask

  task automatic test_partial_fill();
    do_reset();
    step(ord(8'd100, 8'd10), ord(8'd90, 8'd4));
    tests++; if (best_bid !== 8'd100 || best_ask !== 8'd90 || trade_valid !== 1'b0) begin failed++; $display("FAIL pf_book: got bid %0d ask %0d tv %0b expected 100/90/0", best_bid, best_ask, trade_valid); end
    step(NONE, NONE);
    tests++; if (trade_valid !== 1'b1 || trade_price !== 8'd95 || trade_qty !== 8'd4) begin failed++; $display("FAIL pf_trade: got tv %0b p %0d q %0d expected 1/95/4", trade_valid, trade_price, trade_qty); end
    tests++; if (bid_count !== 4'd1 || ask_count !== 4'd0 || best_ask !== 8'd255 || best_bid !== 8'd100) begin failed++; $display("FAIL pf_after: got %0d/%0d bid %0d ask %0d expected 1/0/100/255", bid_count, ask_count, best_bid, best_ask); end
    step(NONE, ord(8'd99, 8'd10));
    tests++; if (trade_valid !== 1'b0 || trade_count !== 16'd1) begin failed++; $display("FAIL pf_gap: got tv %0b cnt %0d expected 0/1", trade_valid, trade_count); end
    step(NONE, NONE);
    tests++; if (trade_qty !== 8'd6 || trade_price !== 8'd99 || trade_valid !== 1'b1) begin failed++; $display("FAIL pf_rest: got tv %0b p %0d q %0d expected 1/99/6", trade_valid, trade_price, trade_qty); end
    tests++; if (bid_count !== 4'd0 || ask_count !== 4'd1 || best_ask !== 8'd99 || trade_count !== 16'd2) begin failed++; $display("FAIL pf_rest_book: got %0d/%0d ask %0d cnt %0d expected 0/1/99/2", bid_count, ask_count, best_ask, trade_count); end
  endtask

  task automatic test_time_priority();
    do_reset();
    step(ord(8'd100, 8'd5), NONE);
    step(ord(8'd100, 8'd5), NONE);
    step(NONE, ord(8'd95, 8'd5));
    step(NONE, NONE);
    tests++; if (trade_valid !== 1'b1 || trade_price !== 8'd97 || trade_qty !== 8'd5) begin failed++; $display("FAIL tp_trade: got tv %0b p %0d q %0d expected 1/97/5", trade_valid, trade_price, trade_qty); end
    tests++; if (bid_count !== 4'd1 || ask_count !== 4'd0) begin failed++; $display("FAIL tp_counts: got %0d/%0d expected 1/0", bid_count, ask_count); end
    do_reset();
    step(ord(8'd100, 8'd5), NONE);
    step(ord(8'd100, 8'd3), NONE);
    step(NONE, ord(8'd95, 8'd4));
    step(NONE, NONE);
    tests++; if (trade_qty !== 8'd4 || bid_count !== 4'd2 || ask_count !== 4'd0) begin failed++; $display("FAIL tp_older: got q %0d counts %0d/%0d expected 4/2/0", trade_qty, bid_count, ask_count); end
  endtask

  task automatic test_multi_fill();
    do_reset();
    step(ord(8'd105, 8'd5), NONE);
    step(ord(8'd103, 8'd5), NONE);
    step(ord(8'd101, 8'd5), NONE);
    step(NONE, ord(8'd100, 8'd20));
    tests++; if (trade_valid !== 1'b0 || bid_count !== 4'd3 || ask_count !== 4'd1) begin failed++; $display("FAIL mf_book: got tv %0b counts %0d/%0d expected 0/3/1", trade_valid, bid_count, ask_count); end
    step(NONE, NONE);
    tests++; if (trade_valid !== 1'b1 || trade_price !== 8'd102 || trade_qty !== 8'd5) begin failed++; $display("FAIL mf_t1: got tv %0b p %0d q %0d expected 1/102/5", trade_valid, trade_price, trade_qty); end
    step(NONE, NONE);
    tests++; if (trade_valid !== 1'b1 || trade_price !== 8'd101 || trade_qty !== 8'd5) begin failed++; $display("FAIL mf_t2: got tv %0b p %0d q %0d expected 1/101/5", trade_valid, trade_price, trade_qty); end
    step(NONE, NONE);
    tests++; if (trade_valid !== 1'b1 || trade_price !== 8'd100 || trade_qty !== 8'd5) begin failed++; $display("FAIL mf_t3: got tv %0b p %0d q %0d expected 1/100/5", trade_valid, trade_price, trade_qty); end
    tests++; if (bid_count !== 4'd0 || ask_count !== 4'd1 || best_ask !== 8'd100 || best_bid !== 8'd0) begin failed++; $display("FAIL mf_after: got %0d/%0d bid %0d ask %0d expected 0/1/0/100", bid_count, ask_count, best_bid, best_ask); end
    step(NONE, NONE);
    tests++; if (trade_valid !== 1'b0 || trade_price !== 8'd100 || trade_count !== 16'd3) begin failed++; $display("FAIL mf_idle: got tv %0b p %0d cnt %0d expected 0/100/3", trade_valid, trade_price, trade_count); end
    step(ord(8'd100, 8'd9), NONE);
    step(NONE, NONE);
    tests++; if (trade_qty !== 8'd5 || ask_count !== 4'd0 || bid_count !== 4'd1) begin failed++; $display("FAIL mf_leftover: got q %0d counts %0d/%0d expected 5/1/0", trade_qty, bid_count, ask_count); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    step(ord(8'd105, 8'd5), NONE);
    step(ord(8'd103, 8'd5), NONE);
    step(ord(8'd101, 8'd5), NONE);
    step(NONE, ord(8'd100, 8'd20));
    step(ord(8'd99, 8'd1), ord(8'd200, 8'd1));
    tests++; if (trade_valid !== 1'b1 || trade_price !== 8'd102) begin failed++; $display("FAIL sim_trade: got tv %0b p %0d expected 1/102", trade_valid, trade_price); end
    tests++; if (bid_count !== 4'd3 || ask_count !== 4'd2 || best_bid !== 8'd103 || best_ask !== 8'd100) begin failed++; $display("FAIL sim_book: got %0d/%0d bid %0d ask %0d expected 3/2/103/100", bid_count, ask_count, best_bid, best_ask); end
    step(NONE, NONE);
    step(NONE, NONE);
    tests++; if (trade_price !== 8'd100 || bid_count !== 4'd1 || best_bid !== 8'd99 || ask_count !== 4'd2) begin failed++; $display("FAIL sim_drain: got p %0d counts %0d/%0d bid %0d expected 100/1/2/99", trade_price, bid_count, ask_count, best_bid); end
    step(NONE, NONE);
    tests++; if (trade_valid !== 1'b0) begin failed++; $display("FAIL sim_stop: got tv %0b expected 0", trade_valid); end
  endtask

  task automatic test_middle_removal();
    do_reset();
    step(NONE, ord(8'd90, 8'd1));
    step(NONE, ord(8'd80, 8'd1));
    step(NONE, ord(8'd95, 8'd1));
    step(ord(8'd85, 8'd1), NONE);
    tests++; if (best_ask !== 8'd80 || ask_count !== 4'd3) begin failed++; $display("FAIL mid_book: got ask %0d cnt %0d expected 80/3", best_ask, ask_count); end
    step(NONE, NONE);
    tests++; if (trade_price !== 8'd82 || ask_count !== 4'd2 || best_ask !== 8'd90 || bid_count !== 4'd0) begin failed++; $display("FAIL mid_trade: got p %0d asks %0d ask %0d bids %0d expected 82/2/90/0", trade_price, ask_count, best_ask, bid_count); end
    step(ord(8'd100, 8'd5), NONE);
    step(NONE, NONE);
    tests++; if (trade_price !== 8'd95 || best_ask !== 8'd95 || ask_count !== 4'd1) begin failed++; $display("FAIL mid_t2: got p %0d ask %0d cnt %0d expected 95/95/1", trade_price, best_ask, ask_count); end
    step(NONE, NONE);
    tests++; if (trade_price !== 8'd97 || ask_count !== 4'd0 || best_bid !== 8'd100) begin failed++; $display("FAIL mid_t3: got p %0d asks %0d bid %0d expected 97/0/100", trade_price, ask_count, best_bid); end
  endtask

  task automatic test_full_side();
    do_reset();
    for (int i = 0; i < 8; i++) step(ord(8'd50, 8'd1), NONE);
    tests++; if (buy_ready !== 1'b0 || bid_count !== 4'd8) begin failed++; $display("FAIL full_ready: got rdy %0b cnt %0d expected 0/8", buy_ready, bid_count); end
    step(ord(8'd60, 8'd1), ord(8'd40, 8'd1));
    tests++; if (buy_ready !== 1'b0 || bid_count !== 4'd8 || ask_count !== 4'd1 || trade_valid !== 1'b0) begin failed++; $display("FAIL full_hold: got rdy %0b counts %0d/%0d tv %0b expected 0/8/1/0", buy_ready, bid_count, ask_count, trade_valid); end
    step(ord(8'd60, 8'd1), NONE);
    tests++; if (trade_valid !== 1'b1 || trade_price !== 8'd45 || bid_count !== 4'd7 || buy_ready !== 1'b1) begin failed++; $display("FAIL full_remove: got tv %0b p %0d cnt %0d rdy %0b expected 1/45/7/1", trade_valid, trade_price, bid_count, buy_ready); end
    step(ord(8'd60, 8'd1), NONE);
    tests++; if (bid_count !== 4'd8 || best_bid !== 8'd60 || buy_ready !== 1'b0) begin failed++; $display("FAIL full_refill: got cnt %0d bid %0d rdy %0b expected 8/60/0", bid_count, best_bid, buy_ready); end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(ord(8'd105, 8'd5), NONE);
    step(ord(8'd103, 8'd5), NONE);
    step(ord(8'd101, 8'd5), NONE);
    step(NONE, ord(8'd100, 8'd20));
    step(NONE, NONE);
    tests++; if (trade_valid !== 1'b1) begin failed++; $display("FAIL ar_pre: got tv %0b expected 1", trade_valid); end
    #2 reset = 1'b1;
    #1;
    tests++; if (trade_valid !== 1'b0 || trade_price !== 8'd0 || trade_qty !== 8'd0 || trade_count !== 16'd0) begin failed++; $display("FAIL ar_trade: got tv %0b p %0d q %0d cnt %0d expected 0/0/0/0", trade_valid, trade_price, trade_qty, trade_count); end
    tests++; if (bid_count !== 4'd0 || ask_count !== 4'd0 || best_bid !== 8'd0 || best_ask !== 8'd255) begin failed++; $display("FAIL ar_book: got %0d/%0d bid %0d ask %0d expected 0/0/0/255", bid_count, ask_count, best_bid, best_ask); end
    @(negedge clk);
    reset = 1'b0;
    tests++; if (buy_ready !== 1'b1 || sell_ready !== 1'b1) begin failed++; $display("FAIL ar_ready: got %0b/%0b expected 1/1", buy_ready, sell_ready); end
    step(ord(8'd70, 8'd3), ord(8'd60, 8'd2));
    step(NONE, NONE);
    tests++; if (trade_valid !== 1'b1 || trade_price !== 8'd65 || trade_qty !== 8'd2 || trade_count !== 16'd1) begin failed++; $display("FAIL ar_after: got tv %0b p %0d q %0d cnt %0d expected 1/65/2/1", trade_valid, trade_price, trade_qty, trade_count); end
  endtask

  initial begin
    test_reset();
    test_zero_qty();
    test_partial_fill();
    test_time_priority();
    test_multi_fill();
    test_simultaneous();
    test_middle_removal();
    test_full_side();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
